// File: rtl/pll_lock_seq.sv
// pll_lock_seq: startup, lock detection, divider-change and brake sequencer for the Canary PLL.
module pll_lock_seq #(
    parameter int DIVN_W       = 8,
    parameter int DIVN_DEFAULT = 32,
    parameter int RST_CYC      = 100,
    parameter int SETTLE_CYC   = 1250,
    parameter int WIN_CYC      = 256,
    parameter int TOL          = 2,
    parameter int LOCK_WINS    = 4,
    parameter int BRAKE_CYC    = 4
) (
    input  logic              refclk,
    input  logic              reset,
    input  logic              fb_tick,
    input  logic              div_req,
    input  logic [DIVN_W-1:0] div_value,
    output logic              div_ack,
    output logic              div_err,
    input  logic              brake_req,
    output logic              pll_resetn,
    output logic              pll_brake,
    output logic [DIVN_W-1:0] pll_divn,
    output logic              locked,
    output logic              lock_lost
);
    localparam int CNT_MAX0 = RST_CYC > SETTLE_CYC ? RST_CYC : SETTLE_CYC;
    localparam int CNT_MAX  = CNT_MAX0 > BRAKE_CYC ? CNT_MAX0 : BRAKE_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int WIN_W    = $clog2(WIN_CYC + 1);
    localparam int FB_W     = $clog2(WIN_CYC + TOL + 2) + 1;
    localparam int GC_W     = $clog2(LOCK_WINS + 1);

    typedef enum logic [2:0] {RST_HOLD, SETTLE, MEASURE, LOCKED, BRAKE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [FB_W-1:0]   fb_cnt;
    logic [GC_W-1:0]   good_cnt;
    logic [FB_W-1:0]   fb_next;
    logic [31:0]       fb_total;
    logic              good;
    logic              win_end;
    logic              div_ok;
    logic              brake_go;

    // window tally including this cycle's tick, window verdict and request qualification
    always_comb begin
        fb_next  = &fb_cnt ? fb_cnt : fb_cnt + FB_W'(fb_tick);
        fb_total = 32'(fb_next);
        good     = (fb_total + 32'(TOL) >= 32'(WIN_CYC)) && (fb_total <= 32'(WIN_CYC + TOL));
        win_end  = win_cnt == WIN_W'(WIN_CYC - 1);
        div_ok   = div_req && div_value >= DIVN_W'(2);
        brake_go = brake_req && (state == MEASURE || state == LOCKED || state == BRAKE);
    end

    // sequencer: accepted divider change beats brake, brake beats window evaluation
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state      <= RST_HOLD;
            cnt        <= '0;
            win_cnt    <= '0;
            fb_cnt     <= '0;
            good_cnt   <= '0;
            pll_resetn <= 1'b0;
            pll_brake  <= 1'b0;
            pll_divn   <= DIVN_W'(DIVN_DEFAULT);
            locked     <= 1'b0;
            div_ack    <= 1'b0;
            div_err    <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            div_ack   <= div_ok;
            div_err   <= div_req && !div_ok;
            lock_lost <= 1'b0;
            if (div_ok) begin
                pll_divn   <= div_value;
                state      <= RST_HOLD;
                cnt        <= '0;
                win_cnt    <= '0;
                fb_cnt     <= '0;
                good_cnt   <= '0;
                pll_resetn <= 1'b0;
                pll_brake  <= 1'b0;
                locked     <= 1'b0;
            end else if (brake_go) begin
                state     <= BRAKE;
                cnt       <= '0;
                pll_brake <= 1'b1;
                locked    <= 1'b0;
            end else begin
                case (state)
                    RST_HOLD: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(RST_CYC - 1)) begin
                            state      <= SETTLE;
                            cnt        <= '0;
                            pll_resetn <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                            state    <= MEASURE;
                            cnt      <= '0;
                            win_cnt  <= '0;
                            fb_cnt   <= '0;
                            good_cnt <= '0;
                        end
                    end
                    MEASURE, LOCKED: begin
                        win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
                        fb_cnt  <= win_end ? '0 : fb_next;
                        if (win_end && state == MEASURE) begin
                            good_cnt <= good ? good_cnt + GC_W'(1) : '0;
                            if (good && good_cnt == GC_W'(LOCK_WINS - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                good_cnt <= '0;
                            end
                        end else if (win_end && !good) begin
                            state     <= MEASURE;
                            good_cnt  <= '0;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                        end
                    end
                    BRAKE: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(BRAKE_CYC - 1)) begin
                            state     <= MEASURE;
                            cnt       <= '0;
                            win_cnt   <= '0;
                            fb_cnt    <= '0;
                            good_cnt  <= '0;
                            pll_brake <= 1'b0;
                        end
                    end
                    default: state <= RST_HOLD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: directed bench with a phase/elapsed-time model of the lock sequencer.
module tb_pll_lock_seq;
    localparam int RST_CYC    = 4;
    localparam int SETTLE_CYC = 8;
    localparam int WIN_CYC    = 16;
    localparam int TOL        = 1;
    localparam int LOCK_WINS  = 2;
    localparam int BRAKE_CYC  = 3;
    localparam int HOLD = 0, SETL = 1, MEAS = 2, LOCK = 3, BRK = 4;

    logic       refclk, reset, fb_tick, div_req, brake_req;
    logic [7:0] div_value;
    logic       div_ack, div_err, pll_resetn, pll_brake, locked, lock_lost;
    logic [7:0] pll_divn;

    int checks = 0;
    int errors = 0;
    int skip = 0;

    int m_mode, m_el, m_ticks, m_goods;
    logic       e_resetn, e_brake, e_locked, e_ack, e_err, e_lost;
    logic [7:0] e_divn;

    pll_lock_seq #(
        .DIVN_W(8), .DIVN_DEFAULT(32), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC),
        .WIN_CYC(WIN_CYC), .TOL(TOL), .LOCK_WINS(LOCK_WINS), .BRAKE_CYC(BRAKE_CYC)
    ) dut (
        .refclk(refclk), .reset(reset), .fb_tick(fb_tick), .div_req(div_req),
        .div_value(div_value), .div_ack(div_ack), .div_err(div_err),
        .brake_req(brake_req), .pll_resetn(pll_resetn), .pll_brake(pll_brake),
        .pll_divn(pll_divn), .locked(locked), .lock_lost(lock_lost)
    );

    initial begin
        refclk = 0;
        forever #5 refclk = ~refclk;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = HOLD; m_el = 0; m_ticks = 0; m_goods = 0;
        e_resetn = 0; e_brake = 0; e_locked = 0; e_ack = 0; e_err = 0; e_lost = 0;
        e_divn = 8'd32;
    endtask

    task automatic enter(input int m);
        m_mode = m; m_el = 0; m_ticks = 0;
    endtask

    task automatic model_step();
        int d;
        bit g;
        if (reset) begin
            model_reset();
            return;
        end
        e_ack = 0; e_err = 0; e_lost = 0;
        if (div_req && div_value >= 8'd2) begin
            e_divn = div_value; e_ack = 1; e_resetn = 0; e_brake = 0; e_locked = 0;
            m_goods = 0; enter(HOLD);
        end else begin
            e_err = div_req;
            if (brake_req && m_mode >= MEAS) begin
                enter(BRK); e_brake = 1; e_locked = 0;
            end else begin
                m_el++;
                if (m_mode == HOLD && m_el == RST_CYC) begin
                    enter(SETL); e_resetn = 1;
                end else if (m_mode == SETL && m_el == SETTLE_CYC) begin
                    enter(MEAS); m_goods = 0;
                end else if (m_mode == BRK && m_el == BRAKE_CYC) begin
                    enter(MEAS); m_goods = 0; e_brake = 0;
                end else if (m_mode == MEAS || m_mode == LOCK) begin
                    m_ticks += int'(fb_tick);
                    if (m_el % WIN_CYC == 0) begin
                        d = m_ticks - WIN_CYC;
                        g = d <= TOL && d >= -TOL;
                        m_ticks = 0;
                        if (m_mode == LOCK && !g) begin
                            m_mode = MEAS; m_goods = 0; e_locked = 0; e_lost = 1;
                        end else if (m_mode == MEAS) begin
                            m_goods = g ? m_goods + 1 : 0;
                            if (m_goods == LOCK_WINS) begin
                                m_mode = LOCK; m_goods = 0; e_locked = 1;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("pll_resetn", 32'(pll_resetn), 32'(e_resetn));
        chk("pll_brake", 32'(pll_brake), 32'(e_brake));
        chk("pll_divn", 32'(pll_divn), 32'(e_divn));
        chk("locked", 32'(locked), 32'(e_locked));
        chk("div_ack", 32'(div_ack), 32'(e_ack));
        chk("div_err", 32'(div_err), 32'(e_err));
        chk("lock_lost", 32'(lock_lost), 32'(e_lost));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge refclk);
            model_step();
            @(negedge refclk);
            if (!reset) compare_all();
            div_req = 0;
            brake_req = 0;
            fb_tick = skip > 0 ? 1'b0 : 1'b1;
            if (skip > 0) skip--;
        end
    endtask

    task automatic drop(input int n);
        fb_tick = 0;
        skip = n - 1;
    endtask

    task automatic wait_align();
        int n = 0;
        while (!((m_mode == MEAS || m_mode == LOCK) && m_el % WIN_CYC == 0) && n < 100) begin
            step(1);
            n++;
        end
        chk("align_timeout", 32'(n < 100), 32'd1);
    endtask

    initial begin
        reset = 1; fb_tick = 1; div_req = 0; div_value = 0; brake_req = 0;
        model_reset();
        repeat (3) @(negedge refclk);
        chk("rst_resetn", 32'(pll_resetn), 32'd0);
        chk("rst_divn", 32'(pll_divn), 32'd32);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_brake", 32'(pll_brake), 32'd0);
        reset = 0;
        // cold start
        step(3);  chk("t1_resetn_hold", 32'(pll_resetn), 32'd0);
        step(1);  chk("t1_resetn_rise", 32'(pll_resetn), 32'd1);
        step(39); chk("t1_not_yet_locked", 32'(locked), 32'd0);
        step(1);  chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_divn", 32'(pll_divn), 32'd32);
        // lock loss with a 13-tick window, relock, then a tolerated 15-tick window
        wait_align(); drop(3); step(15);
        chk("t2_still_locked", 32'(locked), 32'd1);
        step(1);  chk("t2_lock_drop", 32'(locked), 32'd0);
        chk("t2_lock_lost", 32'(lock_lost), 32'd1);
        step(1);  chk("t2_lost_pulse_end", 32'(lock_lost), 32'd0);
        step(30); chk("t2_relock_wait", 32'(locked), 32'd0);
        step(1);  chk("t2_relock", 32'(locked), 32'd1);
        wait_align(); drop(1); step(16);
        chk("t2_15_ticks_locked", 32'(locked), 32'd1);
        chk("t2_15_ticks_no_lost", 32'(lock_lost), 32'd0);
        // single brake, relock, then an extended brake
        brake_req = 1; step(1);
        chk("t3_brake_on", 32'(pll_brake), 32'd1);
        chk("t3_brake_unlock", 32'(locked), 32'd0);
        chk("t3_brake_no_lost", 32'(lock_lost), 32'd0);
        step(2);  chk("t3_brake_third", 32'(pll_brake), 32'd1);
        step(1);  chk("t3_brake_off", 32'(pll_brake), 32'd0);
        step(31); chk("t3_relock_wait", 32'(locked), 32'd0);
        step(1);  chk("t3_relock", 32'(locked), 32'd1);
        brake_req = 1; step(2);
        brake_req = 1; step(1);
        step(2);  chk("t3_ext_fifth", 32'(pll_brake), 32'd1);
        step(1);  chk("t3_ext_off", 32'(pll_brake), 32'd0);
        step(31); step(1);
        chk("t3_relock2", 32'(locked), 32'd1);
        // divider change, brake ignored in SETTLE, rejected divider
        div_value = 8'd40; div_req = 1; step(1);
        chk("t4_ack", 32'(div_ack), 32'd1);
        chk("t4_divn", 32'(pll_divn), 32'd40);
        chk("t4_resetn_low", 32'(pll_resetn), 32'd0);
        chk("t4_unlocked", 32'(locked), 32'd0);
        chk("t4_no_lost", 32'(lock_lost), 32'd0);
        step(1);  chk("t4_ack_pulse_end", 32'(div_ack), 32'd0);
        step(2);  chk("t4_resetn_hold", 32'(pll_resetn), 32'd0);
        step(1);  chk("t4_resetn_rise", 32'(pll_resetn), 32'd1);
        step(2);  brake_req = 1; step(1);
        chk("t4_settle_brake_ignored", 32'(pll_brake), 32'd0);
        step(36); chk("t4_relock_wait", 32'(locked), 32'd0);
        step(1);  chk("t4_relock", 32'(locked), 32'd1);
        div_value = 8'd1; div_req = 1; step(1);
        chk("t4_err", 32'(div_err), 32'd1);
        chk("t4_err_no_ack", 32'(div_ack), 32'd0);
        chk("t4_err_divn", 32'(pll_divn), 32'd40);
        chk("t4_err_locked", 32'(locked), 32'd1);
        // divider and brake on a bad window end
        wait_align(); drop(3); step(15);
        div_value = 8'd50; div_req = 1; brake_req = 1; step(1);
        chk("t5_ack", 32'(div_ack), 32'd1);
        chk("t5_divn", 32'(pll_divn), 32'd50);
        chk("t5_no_brake", 32'(pll_brake), 32'd0);
        chk("t5_no_lost", 32'(lock_lost), 32'd0);
        chk("t5_unlocked", 32'(locked), 32'd0);
        step(44); chk("t5_relock", 32'(locked), 32'd1);
        // asynchronous reset during BRAKE with a non-default divider
        div_value = 8'd40; div_req = 1; step(1);
        step(12);
        brake_req = 1; step(1);
        chk("t6_brake_on", 32'(pll_brake), 32'd1);
        chk("t6_divn40", 32'(pll_divn), 32'd40);
        step(1);
        #2 reset = 1;
        #1;
        chk("t6_async_resetn", 32'(pll_resetn), 32'd0);
        chk("t6_async_brake", 32'(pll_brake), 32'd0);
        chk("t6_async_divn", 32'(pll_divn), 32'd32);
        chk("t6_async_locked", 32'(locked), 32'd0);
        model_reset();
        step(2);
        reset = 0;
        step(3);  chk("t6_resetn_hold", 32'(pll_resetn), 32'd0);
        step(1);  chk("t6_resetn_rise", 32'(pll_resetn), 32'd1);
        chk("t6_divn_default", 32'(pll_divn), 32'd32);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pll_lock_seq.md
Name: pll_lock_seq

Overview:
- Startup and lock sequencer for the Canary PLL, running in the refclk domain.
- Drives the PLL's resetn, brake and divn inputs.
- Judges lock by counting feedback ticks per measurement window and reports lock status.
- Serves divider-change requests and supply-droop brake requests, then relocks after each.

Parameters:
DIVN_W, 8, width of divider value
DIVN_DEFAULT, 32, divn applied after reset
RST_CYC, 100, refclk cycles PLL held in reset
SETTLE_CYC, 1250, refclk cycles after reset release before measuring (10us at 8ns)
WIN_CYC, 256, refclk cycles per lock measurement window
TOL, 2, allowed |fb_count - WIN_CYC| for a good window
LOCK_WINS, 4, consecutive good windows required to declare lock
BRAKE_CYC, 4, refclk cycles pll_brake held per brake event

Ports:
refclk  in  1  reference clock, sole clock
reset  in  1  asynchronous, active-high reset
fb_tick  in  1  one-cycle pulse per divided-feedback edge, already synchronised to refclk
div_req  in  1  request to apply div_value
div_value  in  DIVN_W  requested divider
div_ack  out  1  one-cycle pulse: div_value accepted
div_err  out  1  one-cycle pulse: div_value rejected (<2)
brake_req  in  1  supply-droop brake request
pll_resetn  out  1  to PLL resetn
pll_brake  out  1  to PLL brake
pll_divn  out  DIVN_W  to PLL divn
locked  out  1  PLL judged locked
lock_lost  out  1  one-cycle pulse when locked falls by a failed window

Behaviour:
- All outputs registered.
- Reset values: state RST_HOLD; pll_resetn=0; pll_brake=0; pll_divn=DIVN_DEFAULT; locked=0; div_ack=0; div_err=0; lock_lost=0; all counters 0.
- States: RST_HOLD, SETTLE, MEASURE, LOCKED, BRAKE.
- RST_HOLD:
  - pll_resetn=0.
  - After RST_CYC cycles in state, go to SETTLE.
  - pll_resetn=1 from the first SETTLE cycle.
- SETTLE: after SETTLE_CYC cycles, go to MEASURE; window counter and fb counter cleared.
- MEASURE and LOCKED: measurement window.
  - Window counter runs 0..WIN_CYC-1.
  - fb counter increments on each fb_tick and saturates at all-ones.
  - A tick on the last window cycle is counted.
  - At window end the window is good iff |fb_count - WIN_CYC| <= TOL. Both counters then restart.
- MEASURE window result:
  - Good: good_cnt++.
  - Bad: good_cnt=0.
  - When good_cnt reaches LOCK_WINS, go to LOCKED; locked=1 in the cycle after the deciding window end.
- LOCKED window result:
  - Good: stay.
  - Bad: locked=0, lock_lost pulse (same cycle locked falls), go to MEASURE with good_cnt=0.
- BRAKE:
  - pll_brake=1 for exactly BRAKE_CYC cycles, locked=0.
  - Then go to MEASURE with good_cnt=0 and counters cleared.
  - brake_req while in BRAKE restarts the BRAKE_CYC count.
- brake_req:
  - Honoured in MEASURE, LOCKED and BRAKE.
  - Ignored in RST_HOLD and SETTLE.
  - Entering BRAKE from LOCKED drops locked without lock_lost.
- Divider handshake:
  - div_req is sampled every cycle in any state.
  - If div_value >= 2: pll_divn<=div_value, div_ack pulses the next cycle, go to RST_HOLD (counter restarts, pll_resetn=0, locked=0, no lock_lost).
  - If div_value < 2: div_err pulses, no state change.
  - The requester drops div_req on the cycle it sees ack or err. div_req still high one cycle after ack or err is a new request.
- Priority within one cycle: div_req > brake_req > window-end evaluation. A window end coinciding with an accepted request is discarded.
- Asynchronous reset mid-operation returns immediately to reset values, including pll_divn=DIVN_DEFAULT.

Test Plan:
Use RST_CYC=4, SETTLE_CYC=8, WIN_CYC=16, TOL=1, LOCK_WINS=2, BRAKE_CYC=3 unless noted.
1. Cold start, fb_tick every cycle -> pll_resetn rises 4 cycles after reset release. First window starts 8 cycles later. locked=1 one cycle after the 2nd window end (cycle 4+8+32+1). pll_divn=32 throughout.
2. Lock loss: after lock, one window with 13 ticks -> locked=0 and lock_lost=1 for one cycle at that window end. Relock after 2 further good windows. A window of 15 or 17 ticks does not drop lock.
3. Brake: brake_req for 1 cycle while LOCKED -> pll_brake=1 for exactly 3 cycles, locked=0, no lock_lost, relock after 2 good windows. A second brake_req at BRAKE cycle 2 extends pll_brake to 5 cycles total. brake_req during SETTLE has no effect.
4. Divider change: div_req with div_value=40 while LOCKED -> div_ack for 1 cycle, pll_divn=40, pll_resetn=0 for 4 cycles, full relock sequence. div_value=1 -> div_err only, pll_divn unchanged, locked stays 1.
5. Collision: div_req and brake_req in the same cycle as a bad window end -> divider accepted, no BRAKE, no lock_lost.
6. Reset mid-operation: assert reset during BRAKE with pll_divn=40 -> outputs return asynchronously to pll_resetn=0, pll_brake=0, pll_divn=32, locked=0.
